// File: rtl/lut_neuron_array_pipe.sv
// lut_neuron_array_pipe
// ---------------------------------------------------------------------------
// Array of N_NEURONS independent LUT neurons. Each neuron owns a truth table
// of 2^IN_BITS entries x OUT_BITS, held in distributed RAM and loadable at
// runtime through the cfg_* write port. Lookups for all neurons run in
// lock-step on a 2-stage pipeline (s1: registered addresses, s2: registered
// table outputs).
//
// After reset the block sits in CLEAR for exactly 2^IN_BITS cycles, writing
// zero to one entry of every table per cycle, then moves to RUN for good.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holding valid high keeps
// its data stable until the transfer. in_ready never depends on in_valid;
// out_valid/out_data never depend on out_ready.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     input vector handshake
//   in_data               neuron k address = in_data[k*IN_BITS +: IN_BITS]
//   out_valid/out_ready   result handshake
//   out_data              neuron k result = out_data[k*OUT_BITS +: OUT_BITS]
//   cfg_we                table write strobe (taken when cfg_ready)
//   cfg_neuron/addr/data  write target neuron, entry, value
//   cfg_ready             high in RUN: writes accepted
//   busy                  high while the tables are being cleared
// ---------------------------------------------------------------------------
module lut_neuron_array_pipe #(
  parameter int IN_BITS    = 8,
  parameter int OUT_BITS   = 1,
  parameter int N_NEURONS  = 4,
  parameter int NEUR_IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                          cfg_we,
  input  logic [NEUR_IDX_W-1:0]         cfg_neuron,
  input  logic [IN_BITS-1:0]            cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  output logic                          cfg_ready,
  output logic                          busy
);

  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [IN_BITS-1:0]   clr_cnt_q, clr_cnt_d;
  logic                 run;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state. CLEAR leaves on the cycle that writes the last entry,
  // so it spans exactly DEPTH cycles. RUN is only left through reset.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy      = 1'b1;
    cfg_ready = 1'b0;
    run       = 1'b0;
    case (state_q)
      ST_RUN: begin
        busy      = 1'b0;
        cfg_ready = 1'b1;
        run       = 1'b1;
      end
      default: begin
        busy      = 1'b1;
        cfg_ready = 1'b0;
        run       = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Table write port. The clear sweep and config writes share one port;
  // config writes are simply not steered anywhere while clearing, and an
  // out-of-range cfg_neuron matches no select bit.
  // ---------------------------------------------------------------------
  logic                 mem_we;
  logic [N_NEURONS-1:0] mem_sel;
  logic [IN_BITS-1:0]   mem_addr;
  logic [OUT_BITS-1:0]  mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_sel   = '0;
    mem_addr  = cfg_addr;
    mem_wdata = cfg_data;
    if (!run) begin
      mem_we    = 1'b1;
      mem_sel   = '1;
      mem_addr  = clr_cnt_q;
      mem_wdata = '0;
    end else if (cfg_we) begin
      mem_we = 1'b1;
      for (int k = 0; k < N_NEURONS; k++) begin
        mem_sel[k] = (32'(cfg_neuron) == k);
      end
    end
  end

  // Table storage: no reset, contents come from the clear sweep.
  logic [OUT_BITS-1:0] mem_q [N_NEURONS][DEPTH];

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_NEURONS; k++) begin
      if (mem_we && mem_sel[k]) begin
        mem_q[k][mem_addr] <= mem_wdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Lookup pipeline. Both stages move together whenever s2 is empty or
  // being drained. The table read happens at the same edge as any write,
  // so a same-edge write to the entry being looked up is not yet visible.
  // ---------------------------------------------------------------------
  logic                          s1_valid_q;
  logic [N_NEURONS*IN_BITS-1:0]  s1_addr_q;
  logic                          s2_valid_q;
  logic [N_NEURONS*OUT_BITS-1:0] out_data_q;
  logic                          adv;

  assign adv      = !s2_valid_q || out_ready;
  assign in_ready = run && adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
    end else if (adv) begin
      s1_valid_q <= in_valid && in_ready;
      s1_addr_q  <= in_data;
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        for (int k = 0; k < N_NEURONS; k++) begin
          out_data_q[k*OUT_BITS +: OUT_BITS] <= mem_q[k][s1_addr_q[k*IN_BITS +: IN_BITS]];
        end
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_lut_neuron_array_pipe.sv
// Bench for lut_neuron_array_pipe with IN_BITS=8, OUT_BITS=1, N_NEURONS=3
// (three neurons leave cfg_neuron=3 as a representable out-of-range index).
// Neuron 0 is loaded with f(a) = a[0] & ~a[3]; neurons 1 and 2 stay zero
// except for the collision entry (neuron 1, 0x3C).
module tb_lut_neuron_array_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_data;
  logic        cfg_we;
  logic [1:0]  cfg_neuron;
  logic [7:0]  cfg_addr;
  logic [0:0]  cfg_data;
  logic        cfg_ready;
  logic        busy;

  lut_neuron_array_pipe #(
    .IN_BITS  (8),
    .OUT_BITS (1),
    .N_NEURONS(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_neuron(cfg_neuron),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .busy      (busy)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic       tbl [3][256];
  logic [2:0] exp_q [$];
  int         n_in, n_out, sidx, first_acc, first_out;
  bit         stall_prev;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [23:0] pack(input logic [7:0] a0, input logic [7:0] a1,
                                       input logic [7:0] a2);
    return {a2, a1, a0};
  endfunction

  function automatic logic [2:0] exp_of(input logic [23:0] d);
    return {tbl[2][d[23:16]], tbl[1][d[15:8]], tbl[0][d[7:0]]};
  endfunction

  task automatic model_clear();
    for (int n = 0; n < 3; n++)
      for (int a = 0; a < 256; a++)
        tbl[n][a] = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle of the stream driver. Called at a falling edge with the
  // inputs already driven; samples what will transfer on the next rising edge.
  task automatic cycle(output bit acc);
    logic [2:0] e;
    #1;
    acc = in_valid && in_ready;
    if (stall_prev) check_eq("hold_valid", 32'(out_valid), 32'd1);
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 32'(out_valid), 32'd0);
      end else if (out_ready) begin
        e = exp_q.pop_front();
        check_eq("stream_data", 32'(out_data), 32'(e));
        n_out++;
        if (first_out < 0) first_out = sidx;
      end else begin
        check_eq("hold_data", 32'(out_data), 32'(exp_q[0]));
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      end
    end
    stall_prev = out_valid && !out_ready;
    if (acc) begin
      exp_q.push_back(exp_of(in_data));
      n_in++;
      if (first_acc < 0) first_acc = sidx;
    end
    sidx++;
    @(negedge clk);
  endtask

  task automatic cfg_write(input int n, input logic [7:0] a, input logic d);
    cfg_we     = 1'b1;
    cfg_neuron = 2'(n);
    cfg_addr   = a;
    cfg_data   = d;
    @(negedge clk);
    cfg_we = 1'b0;
    if (n < 3) tbl[n][a] = d;
  endtask

  // Single lookup on an idle pipeline, compared with a hand-computed result.
  task automatic lookup_one(input string tag, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input logic [2:0] exp);
    int c;
    in_valid  = 1'b1;
    in_data   = pack(a0, a1, a2);
    out_ready = 1'b1;
    c = 0;
    #1;
    while (!in_ready && c < 20) begin
      @(negedge clk); #1; c++;
    end
    check_eq({tag, "_acc"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    c = 0;
    #1;
    while (!out_valid && c < 20) begin
      @(negedge clk); #1; c++;
    end
    check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
    check_eq(tag, 32'(out_data), 32'(exp));
    @(negedge clk);
  endtask

  // Counts the sampled cycles with busy high after reset release.
  task automatic wait_clear(output int cnt, output bit saw_rdy, output bit saw_vld,
                            output bit saw_cfg);
    cnt = 0; saw_rdy = 0; saw_vld = 0; saw_cfg = 0;
    #1;
    while (busy && cnt < 1000) begin
      if (in_ready)  saw_rdy = 1;
      if (out_valid) saw_vld = 1;
      if (cfg_ready) saw_cfg = 1;
      cnt++;
      @(negedge clk); #1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit  acc, sr, sv, sc;
    int  cnt, idx;
    logic f;

    rst_n = 1'b1; in_valid = 0; in_data = '0; out_ready = 1'b1;
    cfg_we = 0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    model_clear();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_busy",      32'(busy),      32'd1);
    check_eq("rst_in_ready",  32'(in_ready),  32'd0);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data",  32'(out_data),  32'd0);

    // Release; push a vector and a config write during CLEAR (both ignored).
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = pack(8'h11, 8'h22, 8'h05);
    cfg_we = 1'b1; cfg_neuron = 2'd2; cfg_addr = 8'h05; cfg_data = 1'b1;
    wait_clear(cnt, sr, sv, sc);
    in_valid = 1'b0; cfg_we = 1'b0;
    check_eq("clear_len",       32'(cnt), 32'd256);
    check_eq("clear_in_ready",  32'(sr),  32'd0);
    check_eq("clear_cfg_ready", 32'(sc),  32'd0);
    check_eq("clear_out_valid", 32'(sv),  32'd0);
    check_eq("run_busy",        32'(busy),      32'd0);
    check_eq("run_cfg_ready",   32'(cfg_ready), 32'd1);
    check_eq("run_in_ready",    32'(in_ready),  32'd1);
    @(negedge clk);
    #1 check_eq("no_out_from_clear", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Cleared tables read zero.
    lookup_one("zero_a", 8'h00, 8'hFF, 8'h05, 3'b000);
    lookup_one("zero_b", 8'h87, 8'h3C, 8'h80, 3'b000);

    // Out-of-range neuron index: nothing may change.
    cfg_write(3, 8'h07, 1'b1);

    // Load neuron 0 with f(a) = a[0] & ~a[3].
    for (int a = 0; a < 256; a++) begin
      f = ((a % 2) == 1) && ((a & 8) == 0);
      cfg_write(0, 8'(a), f);
    end

    lookup_one("lut_00", 8'h00, 8'h07, 8'h05, 3'b000);
    lookup_one("lut_01", 8'h01, 8'h07, 8'h05, 3'b001);
    lookup_one("lut_08", 8'h08, 8'h07, 8'h05, 3'b000);
    lookup_one("lut_09", 8'h09, 8'h07, 8'h05, 3'b000);
    lookup_one("lut_40", 8'h40, 8'h07, 8'h05, 3'b000);
    lookup_one("lut_87", 8'h87, 8'h07, 8'h05, 3'b001);

    // Back-to-back stream of all 256 addresses.
    n_in = 0; n_out = 0; sidx = 0; first_acc = -1; first_out = -1; stall_prev = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = pack(8'(i), 8'(i ^ 'h55), 8'(~i));
      cycle(acc);
      check_eq("stream_accept", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) cycle(acc);
    check_eq("stream_count",   32'(n_out), 32'd256);
    check_eq("stream_latency", 32'(first_out - first_acc), 32'd2);
    check_eq("stream_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: out_ready low for 5 cycles mid-stream.
    n_in = 0; n_out = 0; idx = 0; stall_prev = 0;
    for (int c = 0; c < 60 && (idx < 20 || exp_q.size() > 0); c++) begin
      in_valid  = (idx < 20);
      in_data   = pack(8'(idx * 7 + 3), 8'(idx), 8'(255 - idx));
      out_ready = !(c >= 6 && c < 11);
      cycle(acc);
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("bp_in_count",  32'(n_in),  32'd20);
    check_eq("bp_out_count", 32'(n_out), 32'd20);
    check_eq("bp_drained",   32'(exp_q.size()), 32'd0);

    // Same-edge collision: write neuron 1 @0x3C while s1 holds 0x3C.
    in_valid = 1'b1; in_data = pack(8'h00, 8'h3C, 8'h00); out_ready = 1'b1;
    #1 check_eq("coll_acc", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_neuron = 2'd1; cfg_addr = 8'h3C; cfg_data = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    tbl[1][8'h3C] = 1'b1;
    #1;
    check_eq("coll_old_vld", 32'(out_valid), 32'd1);
    check_eq("coll_old",     32'(out_data),  32'd0);
    @(negedge clk);
    lookup_one("coll_new", 8'h00, 8'h3C, 8'h00, 3'b010);

    // Reset with two vectors in flight.
    in_valid = 1'b1; in_data = pack(8'h01, 8'h3C, 8'h00); out_ready = 1'b1;
    @(negedge clk);
    in_data = pack(8'h87, 8'h3C, 8'h00);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 check_eq("inflight_vld", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_out_data",  32'(out_data),  32'd0);
    check_eq("mid_rst_busy",      32'(busy),      32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    model_clear();
    exp_q.delete();
    wait_clear(cnt, sr, sv, sc);
    check_eq("reclear_len",       32'(cnt), 32'd256);
    check_eq("reclear_out_valid", 32'(sv),  32'd0);
    @(negedge clk);
    stall_prev = 0;
    for (int c = 0; c < 5; c++) cycle(acc);
    lookup_one("reclear_a", 8'h01, 8'h3C, 8'h05, 3'b000);
    lookup_one("reclear_b", 8'h87, 8'h3C, 8'h00, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
